// File: rtl/health_controller_if.sv
// Hit/frame control bus between game logic and one player's health controller.
// The master side drives events; the slave side reports health and status.
interface health_controller_if;
   logic       frame_tick;
   logic       new_round;
   logic       hit_valid;
   logic [7:0] hit_damage;
   logic       block_active;
   logic [8:0] curr_health;
   logic       hit_ack;
   logic       hit_ignored;
   logic       invuln;
   logic [3:0] combo_count;
   logic       ko;
   logic       ko_pulse;

   modport master (
      output frame_tick, new_round, hit_valid, hit_damage, block_active,
      input  curr_health, hit_ack, hit_ignored, invuln, combo_count, ko, ko_pulse
   );

   modport slave (
      input  frame_tick, new_round, hit_valid, hit_damage, block_active,
      output curr_health, hit_ack, hit_ignored, invuln, combo_count, ko, ko_pulse
   );
endinterface

// File: rtl/health_controller.sv
// Per-player health controller.
// Handles damage with block chip reduction, frame-counted invulnerability, combo tracking and KO.
module health_controller #(
   parameter int FULL_HEALTH   = 200,
   parameter int INVULN_FRAMES = 20,
   parameter int COMBO_FRAMES  = 30,
   parameter int CHIP_SHIFT    = 2
) (
   input logic               clk,
   input logic               reset,
   health_controller_if.slave bus
);

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      KO     = 2'd2
   } state_t;

   localparam logic [8:0]  FullHealth   = 9'(FULL_HEALTH);
   localparam logic [15:0] InvulnFrames = 16'(INVULN_FRAMES);
   localparam logic [15:0] ComboFrames  = 16'(COMBO_FRAMES);

   state_t      state_q;
   logic [8:0]  health_q;
   logic [15:0] invCnt_q;
   logic [15:0] comboCnt_q;
   logic [3:0]  comboCount_q;
   logic        hitAck_q;
   logic        hitIgnored_q;
   logic        koPulse_q;

   logic [8:0]  rawDamage_d;
   logic [8:0]  eff_d;
   logic [8:0]  newHealth_d;

   // Damage is widened to 9 bits first so the subtraction compares cleanly against health.
   assign rawDamage_d = {1'b0, bus.hit_damage};
   assign eff_d       = bus.block_active ? (rawDamage_d >> CHIP_SHIFT) : rawDamage_d;
   assign newHealth_d = (health_q > eff_d) ? (health_q - eff_d) : 9'd0;

   // Hit handling in ALIVE overrides the combo-timer decay from the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ALIVE;
         health_q     <= FullHealth;
         invCnt_q     <= '0;
         comboCnt_q   <= '0;
         comboCount_q <= '0;
         hitAck_q     <= 1'b0;
         hitIgnored_q <= 1'b0;
         koPulse_q    <= 1'b0;
      end else begin
         hitAck_q     <= 1'b0;
         hitIgnored_q <= 1'b0;
         koPulse_q    <= 1'b0;
         if (bus.new_round) begin
            state_q      <= ALIVE;
            health_q     <= FullHealth;
            invCnt_q     <= '0;
            comboCnt_q   <= '0;
            comboCount_q <= '0;
         end else begin
            if (bus.frame_tick && comboCount_q != 4'd0) begin
               if (comboCnt_q <= 16'd1) begin
                  comboCnt_q   <= '0;
                  comboCount_q <= '0;
               end else begin
                  comboCnt_q <= comboCnt_q - 16'd1;
               end
            end
            case (state_q)
               ALIVE: begin
                  if (bus.hit_valid) begin
                     hitAck_q <= 1'b1;
                     health_q <= newHealth_d;
                     if (newHealth_d == 9'd0) begin
                        state_q   <= KO;
                        koPulse_q <= 1'b1;
                     end else if (eff_d != 9'd0) begin
                        state_q  <= INVULN;
                        invCnt_q <= InvulnFrames;
                     end
                     if (bus.block_active) begin
                        comboCount_q <= '0;
                        comboCnt_q   <= '0;
                     end else if (eff_d != 9'd0) begin
                        comboCount_q <= (comboCount_q == 4'd15) ? 4'd15 : comboCount_q + 4'd1;
                        comboCnt_q   <= ComboFrames;
                     end
                  end
               end
               INVULN: begin
                  if (bus.hit_valid) begin
                     hitIgnored_q <= 1'b1;
                  end
                  if (bus.frame_tick) begin
                     if (invCnt_q <= 16'd1) begin
                        invCnt_q <= '0;
                        state_q  <= ALIVE;
                     end else begin
                        invCnt_q <= invCnt_q - 16'd1;
                     end
                  end
               end
               KO: begin
                  if (bus.hit_valid) begin
                     hitIgnored_q <= 1'b1;
                  end
               end
               default: state_q <= ALIVE;
            endcase
         end
      end
   end

   assign bus.curr_health = health_q;
   assign bus.hit_ack     = hitAck_q;
   assign bus.hit_ignored = hitIgnored_q;
   assign bus.invuln      = (state_q == INVULN);
   assign bus.combo_count = comboCount_q;
   assign bus.ko          = (state_q == KO);
   assign bus.ko_pulse    = koPulse_q;

endmodule

// File: tb/tb_health_controller.sv
// Directed testbench for health_controller: damage, block chip, invulnerability,
// combo decay, KO, new_round priority and asynchronous reset.
module tb_health_controller;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   health_controller_if hif();

   health_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif.slave)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, then return everything to idle
   task automatic applyStimulus(input logic hv, input logic [7:0] dmg, input logic blk,
                                input logic ft, input logic nr);
      hif.hit_valid    = hv;
      hif.hit_damage   = dmg;
      hif.block_active = blk;
      hif.frame_tick   = ft;
      hif.new_round    = nr;
      step();
      hif.hit_valid    = 1'b0;
      hif.hit_damage   = 8'd0;
      hif.block_active = 1'b0;
      hif.frame_tick   = 1'b0;
      hif.new_round    = 1'b0;
   endtask

   // Each frame is one tick cycle followed by one idle cycle
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
         step();
      end
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      hif.frame_tick   = 1'b0;
      hif.new_round    = 1'b0;
      hif.hit_valid    = 1'b0;
      hif.hit_damage   = 8'd0;
      hif.block_active = 1'b0;
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();

      $display("[TB] reset and idle");
      checkOutput("reset_health", 16'(hif.curr_health), 16'd200);
      checkOutput("reset_ko", 16'(hif.ko), 16'd0);
      checkOutput("reset_invuln", 16'(hif.invuln), 16'd0);
      checkOutput("reset_combo", 16'(hif.combo_count), 16'd0);
      checkOutput("reset_ack", 16'(hif.hit_ack), 16'd0);

      $display("[TB] unblocked hit of 30");
      applyStimulus(1'b1, 8'd30, 1'b0, 1'b0, 1'b0);
      checkOutput("hit1_health", 16'(hif.curr_health), 16'd170);
      checkOutput("hit1_ack", 16'(hif.hit_ack), 16'd1);
      checkOutput("hit1_invuln", 16'(hif.invuln), 16'd1);
      checkOutput("hit1_combo", 16'(hif.combo_count), 16'd1);
      step();
      checkOutput("hit1_ack_width", 16'(hif.hit_ack), 16'd0);

      frames(5);
      applyStimulus(1'b1, 8'd30, 1'b0, 1'b0, 1'b0);
      checkOutput("inv_hit_ignored", 16'(hif.hit_ignored), 16'd1);
      checkOutput("inv_hit_ack", 16'(hif.hit_ack), 16'd0);
      checkOutput("inv_hit_health", 16'(hif.curr_health), 16'd170);
      checkOutput("inv_hit_combo", 16'(hif.combo_count), 16'd1);

      frames(14);
      checkOutput("inv_after19", 16'(hif.invuln), 16'd1);
      $display("[TB] hit coincident with final invulnerability tick");
      applyStimulus(1'b1, 8'd30, 1'b0, 1'b1, 1'b0);
      checkOutput("last_tick_ignored", 16'(hif.hit_ignored), 16'd1);
      checkOutput("last_tick_invuln", 16'(hif.invuln), 16'd0);
      checkOutput("last_tick_health", 16'(hif.curr_health), 16'd170);
      step();

      $display("[TB] blocked hits");
      applyStimulus(1'b1, 8'd30, 1'b1, 1'b0, 1'b0);
      checkOutput("blk30_health", 16'(hif.curr_health), 16'd163);
      checkOutput("blk30_ack", 16'(hif.hit_ack), 16'd1);
      checkOutput("blk30_combo", 16'(hif.combo_count), 16'd0);
      checkOutput("blk30_invuln", 16'(hif.invuln), 16'd1);
      frames(20);
      checkOutput("blk30_inv_end", 16'(hif.invuln), 16'd0);
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
      checkOutput("blk3_ack", 16'(hif.hit_ack), 16'd1);
      checkOutput("blk3_health", 16'(hif.curr_health), 16'd163);
      checkOutput("blk3_invuln", 16'(hif.invuln), 16'd0);

      $display("[TB] combo across invulnerability windows");
      applyStimulus(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
      checkOutput("combo1_health", 16'(hif.curr_health), 16'd153);
      checkOutput("combo1_count", 16'(hif.combo_count), 16'd1);
      frames(25);
      checkOutput("combo_gap_invuln", 16'(hif.invuln), 16'd0);
      checkOutput("combo_gap_count", 16'(hif.combo_count), 16'd1);
      applyStimulus(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
      checkOutput("combo2_health", 16'(hif.curr_health), 16'd143);
      checkOutput("combo2_count", 16'(hif.combo_count), 16'd2);
      frames(29);
      checkOutput("combo_decay29", 16'(hif.combo_count), 16'd2);
      frames(1);
      checkOutput("combo_decay30", 16'(hif.combo_count), 16'd0);

      $display("[TB] saturating KO");
      applyStimulus(1'b1, 8'd133, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_ko_health", 16'(hif.curr_health), 16'd10);
      frames(20);
      applyStimulus(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
      checkOutput("ko_health", 16'(hif.curr_health), 16'd0);
      checkOutput("ko_level", 16'(hif.ko), 16'd1);
      checkOutput("ko_pulse", 16'(hif.ko_pulse), 16'd1);
      checkOutput("ko_ack", 16'(hif.hit_ack), 16'd1);
      step();
      checkOutput("ko_pulse_width", 16'(hif.ko_pulse), 16'd0);
      checkOutput("ko_level_hold", 16'(hif.ko), 16'd1);
      applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
      checkOutput("ko_hit_ignored", 16'(hif.hit_ignored), 16'd1);
      checkOutput("ko_hit_health", 16'(hif.curr_health), 16'd0);

      $display("[TB] new_round with simultaneous hit");
      applyStimulus(1'b1, 8'd50, 1'b0, 1'b1, 1'b1);
      checkOutput("nr_health", 16'(hif.curr_health), 16'd200);
      checkOutput("nr_ko", 16'(hif.ko), 16'd0);
      checkOutput("nr_ack", 16'(hif.hit_ack), 16'd0);
      checkOutput("nr_ignored", 16'(hif.hit_ignored), 16'd0);
      checkOutput("nr_combo", 16'(hif.combo_count), 16'd0);

      $display("[TB] asynchronous reset during invulnerability");
      applyStimulus(1'b1, 8'd80, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_health", 16'(hif.curr_health), 16'd120);
      checkOutput("pre_rst_invuln", 16'(hif.invuln), 16'd1);
      frames(3);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_health", 16'(hif.curr_health), 16'd200);
      checkOutput("arst_invuln", 16'(hif.invuln), 16'd0);
      checkOutput("arst_combo", 16'(hif.combo_count), 16'd0);
      checkOutput("arst_ko", 16'(hif.ko), 16'd0);
      step();
      reset = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
